class_vote: RTL and testbench

CLASS_VOTE -- requirements
Module: class_vote

---
 rtl/class_vote_pkg.sv | 31 +++
 rtl/vote_window.sv | 60 ++++++
 rtl/class_vote.sv | 131 +++++++++++++
 tb/tb_class_vote.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/class_vote_pkg.sv
`default_nettype none
// ============================================================================
// Module  : class_vote_pkg
// Brief   : Shared types, defaults and helpers for the class_vote filter.
// Revision: 1.0 - initial release
// ============================================================================
package class_vote_pkg;

    // Decision FSM encoding
    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } vote_state_t;

    // Default window geometry and hysteresis thresholds
    localparam int DEF_WIN   = 8;
    localparam int DEF_HI_TH = 6;
    localparam int DEF_LO_TH = 2;

    // Ones-count width (covers WIN up to 16) and drop counter width
    localparam int CNT_W  = 5;
    localparam int DROP_W = 8;

    // Saturating increment for the drop counter
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vote_window.sv
`default_nettype none
// ============================================================================
// Module  : vote_window
// Brief   : WIN-sample history with incremental ones-count and warm-up
//           tracking. count_next_o is the count after the current sample.
// Revision: 1.0 - initial release
// ============================================================================
module vote_window
    import class_vote_pkg::*;
#(
    parameter int WIN = DEF_WIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             class_i,
    output logic [CNT_W-1:0] count_next_o,
    output logic             warm_last_o
);

    localparam logic [CNT_W-1:0] WIN_C      = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] WIN_LAST_C = CNT_W'(WIN - 1);

    logic [WIN-1:0]   hist_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] warm_q;
    logic             full;
    logic             oldest;
    logic [CNT_W-1:0] count_d;

    // Oldest sample only leaves the window once the window has filled
    always_comb begin
        full    = (warm_q == WIN_C);
        oldest  = full ? hist_q[WIN-1] : 1'b0;
        count_d = count_q;
        if (valid_i) begin
            count_d = count_q + CNT_W'(class_i) - CNT_W'(oldest);
        end
    end

    assign count_next_o = count_d;
    assign warm_last_o  = valid_i && (warm_q == WIN_LAST_C);

    // History shift, running count and warm-up counter (saturates at WIN)
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q  <= '0;
            count_q <= '0;
            warm_q  <= '0;
        end else if (valid_i) begin
            hist_q  <= {hist_q[WIN-2:0], class_i};
            count_q <= count_d;
            if (!full) begin
                warm_q <= warm_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/class_vote.sv
`default_nettype none
// ============================================================================
// Module  : class_vote
// Brief   : Hysteresis vote filter over a sliding window of classifier
//           samples; emits a decision event on each state change, with a
//           single-entry overwrite buffer and a saturating drop counter.
// Revision: 1.0 - initial release
// ============================================================================
module class_vote
    import class_vote_pkg::*;
#(
    parameter int WIN   = DEF_WIN,
    parameter int HI_TH = DEF_HI_TH,
    parameter int LO_TH = DEF_LO_TH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_class,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_class,
    output logic [CNT_W-1:0]  out_count,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO_TH);

    logic [CNT_W-1:0] count_next;
    logic             warm_last;

    vote_window #(
        .WIN (WIN)
    ) u_window (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (in_valid),
        .class_i      (in_class),
        .count_next_o (count_next),
        .warm_last_o  (warm_last)
    );

    vote_state_t       state_q, state_d;
    logic              fire;
    logic              ev_class;

    logic              valid_q, valid_d;
    logic              class_q, class_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DROP_W-1:0] drop_q,  drop_d;

    // Decision FSM: hysteresis thresholds evaluated on the post-sample count
    always_comb begin
        state_d  = state_q;
        fire     = 1'b0;
        ev_class = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_WARMUP: begin
                    if (warm_last) begin
                        fire = 1'b1;
                        if (count_next >= HI_C) begin
                            state_d  = ST_HIGH;
                            ev_class = 1'b1;
                        end else begin
                            state_d  = ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (count_next >= HI_C) begin
                        state_d  = ST_HIGH;
                        fire     = 1'b1;
                        ev_class = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (count_next <= LO_C) begin
                        state_d = ST_LOW;
                        fire    = 1'b1;
                    end
                end
                default: state_d = ST_WARMUP;
            endcase
        end
    end

    // Event buffer: a new event replaces a pending one, counting a drop
    // only if the pending event is not being accepted this cycle
    always_comb begin
        valid_d = valid_q;
        class_d = class_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (fire) begin
            valid_d = 1'b1;
            class_d = ev_class;
            count_d = count_next;
            if (valid_q && !out_ready) begin
                drop_d = sat_inc(drop_q);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WARMUP;
            valid_q <= 1'b0;
            class_q <= 1'b0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            class_q <= class_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign out_valid = valid_q;
    assign out_class = class_q;
    assign out_count = count_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_class_vote.sv
`default_nettype none
// ============================================================================
// Module  : tb_class_vote
// Brief   : Scoreboard bench for class_vote (WIN=8, HI_TH=6, LO_TH=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_class_vote;

    localparam int WIN   = 8;
    localparam int HI_TH = 6;
    localparam int LO_TH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_class;
    logic       out_ready;
    logic       out_valid;
    logic       out_class;
    logic [4:0] out_count;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    class_vote #(
        .WIN   (WIN),
        .HI_TH (HI_TH),
        .LO_TH (LO_TH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_class  (in_class),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .drop_cnt  (drop_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: window as a sample queue, count by summation
    typedef struct {
        bit c;
        int n;
    } ev_t;

    bit  mh[$];
    int  mstate = 0;
    bit  mv     = 1'b0;
    bit  mc     = 1'b0;
    int  mcount = 0;
    int  mdrop  = 0;
    ev_t sb[$];

    task automatic step(input bit v, input bit c, input bit rdy, input bit r);
        int  cnt;
        bit  fire;
        bit  ecls;
        ev_t e;
        rst       = r;
        in_valid  = v;
        in_class  = c;
        out_ready = rdy;
        cnt  = 0;
        fire = 1'b0;
        ecls = 1'b0;
        // Acceptance happens on the coming edge: compare the pending event now
        if (!r && mv && rdy) begin
            e = sb.pop_front();
            chk("acc_class", 32'(out_class), 32'(e.c));
            chk("acc_count", 32'(out_count), 32'(e.n));
        end
        if (r) begin
            mh.delete();
            sb.delete();
            mstate = 0;
            mv     = 1'b0;
            mc     = 1'b0;
            mcount = 0;
            mdrop  = 0;
        end else begin
            if (v) begin
                mh.push_back(c);
                if (mh.size() > WIN) void'(mh.pop_front());
                foreach (mh[i]) cnt += int'(mh[i]);
                if (mstate == 0) begin
                    if (mh.size() == WIN) begin
                        fire   = 1'b1;
                        ecls   = (cnt >= HI_TH);
                        mstate = ecls ? 2 : 1;
                    end
                end else if (mstate == 1 && cnt >= HI_TH) begin
                    fire = 1'b1; ecls = 1'b1; mstate = 2;
                end else if (mstate == 2 && cnt <= LO_TH) begin
                    fire = 1'b1; ecls = 1'b0; mstate = 1;
                end
            end
            if (fire) begin
                if (mv && !rdy) begin
                    if (mdrop < 255) mdrop++;
                    void'(sb.pop_back());
                end
                e.c = ecls;
                e.n = cnt;
                sb.push_back(e);
                mv     = 1'b1;
                mc     = ecls;
                mcount = cnt;
            end else if (mv && rdy) begin
                mv = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(mv));
        chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
        if (mv) begin
            chk("hold_class", 32'(out_class), 32'(mc));
            chk("hold_count", 32'(out_count), 32'(mcount));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_class  = 1'b0;
        out_ready = 1'b0;

        // Reset, with in_valid asserted during reset ignored
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_class", 32'(out_class), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);

        // Warm-up with eight ones -> HIGH, count 8
        repeat (7) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("warm_no_ev", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("warm_valid", 32'(out_valid), 32'd1);
        chk("warm_class", 32'(out_class), 32'd1);
        chk("warm_count", 32'(out_count), 32'd8);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Zeros: counts 7..3 hold, sixth zero reaches 2 -> LOW
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("hyst_no_ev", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("low_class", 32'(out_class), 32'd0);
        chk("low_count", 32'(out_count), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Back to HIGH (count 6), accepted
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("high_count", 32'(out_count), 32'd6);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: HIGH->LOW then LOW->HIGH while not ready
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("bp_first_class", 32'(out_class), 32'd0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_class", 32'(out_class), 32'd1);
        chk("bp_drop",  32'(drop_cnt),  32'd1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_released", 32'(out_valid), 32'd0);

        // Acceptance coinciding with a new transition: no drop
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("same_valid", 32'(out_valid), 32'd1);
        chk("same_class", 32'(out_class), 32'd1);
        chk("same_count", 32'(out_count), 32'd6);
        chk("same_drop",  32'(drop_cnt),  32'd1);

        // Idle cycles with toggling in_class while an event is pending
        for (int i = 0; i < 20; i++) step(1'b0, bit'(i % 2), 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("idle_class", 32'(out_class), 32'd0);
        chk("idle_count", 32'(out_count), 32'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid warm-up restarts the window
        repeat (5) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rewarm_no_ev", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("rewarm_valid", 32'(out_valid), 32'd1);
        chk("rewarm_class", 32'(out_class), 32'd1);
        chk("rewarm_count", 32'(out_count), 32'd8);
        chk("rewarm_drop",  32'(drop_cnt),  32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 79) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
